// File: rtl/logic_unit_seq_if.sv
// Request/response bundle for logic_unit_seq: request handshake with operands,
// response handshake with registered result and zero flag.
interface logic_unit_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out1;
  logic             zero;

  modport master (
    output in_valid, op, in1, in2, out_ready,
    input  in_ready, out_valid, out1, zero
  );

  modport slave (
    input  in_valid, op, in1, in2, out_ready,
    output in_ready, out_valid, out1, zero
  );
endinterface

// File: rtl/logic_unit_seq.sv
// Chunk-serial bitwise logic unit: applies AND/OR/XOR/NOR to latched operands
// CHUNK bits per cycle (LSB chunk first) and presents a registered result.
module logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic             clk,
  input logic             rst,
  logic_unit_seq_if.slave bus
);
  localparam int NCH   = WIDTH / CHUNK;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("logic_unit_seq: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [1:0]         op_q,    op_d;
  logic [WIDTH-1:0]   a_q,     a_d;
  logic [WIDTH-1:0]   b_q,     b_d;
  logic [WIDTH-1:0]   acc_q,   acc_d;
  logic [WIDTH-1:0]   out1_q,  out1_d;
  logic               zero_q,  zero_d;

  function automatic logic [CHUNK-1:0] apply_op(input logic [1:0]       op,
                                                input logic [CHUNK-1:0] a,
                                                input logic [CHUNK-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Stage boundary: control and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out1_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out1_q  <= out1_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out1_d  = out1_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.op;
          a_d     = bus.in1;
          b_d     = bus.in2;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Constant-index loop keeps the chunk select a plain mux on cnt_q
        for (int i = 0; i < NCH; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            acc_d[i*CHUNK +: CHUNK] = apply_op(op_q, a_q[i*CHUNK +: CHUNK],
                                               b_q[i*CHUNK +: CHUNK]);
          end
        end
        if (cnt_q == CNT_W'(NCH - 1)) begin
          out1_d  = acc_d;
          zero_d  = (acc_d == '0);
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out1      = out1_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: directed vectors on the 32/8 build plus
// back-to-back model comparison on the 32/32 and 8/1 builds.
module tb_logic_unit_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  logic_unit_seq_if #(.WIDTH(32)) bus   ();
  logic_unit_seq_if #(.WIDTH(32)) bus32 ();
  logic_unit_seq_if #(.WIDTH(8))  bus8  ();

  logic_unit_seq #(.WIDTH(32), .CHUNK(8))  u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
  logic_unit_seq #(.WIDTH(32), .CHUNK(32)) u_c32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  logic_unit_seq #(.WIDTH(8),  .CHUNK(1))  u_w8  (.clk(clk), .rst(rst), .bus(bus8.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input int w);
    logic [31:0] r, mask;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~(a | b);
    endcase
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    return r & mask;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE, scramble inputs after accept, wait for out_valid
  task automatic req32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    int lat;
    bus.op = op; bus.in1 = a; bus.in2 = b; bus.in_valid = 1'b1;
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0; bus.in1 = 32'hFFFF_FFFF; bus.in2 = $urandom; bus.op = ~op;
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
  endtask

  task automatic sweep32();
    logic [1:0] op; logic [31:0] a, b, exp; int lat;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom_range(3)); a = $urandom; b = $urandom;
      exp = ref_op(op, a, b, 32);
      bus32.op = op; bus32.in1 = a; bus32.in2 = b; bus32.in_valid = 1'b1;
      tick();
      bus32.in_valid = 1'b0; bus32.in1 = ~a; bus32.in2 = ~b;
      lat = 0;
      while (!bus32.out_valid && lat < 16) begin tick(); lat++; end
      chk("c32_latency", lat, 1);
      chk("c32_out1", bus32.out1, exp);
      chk("c32_zero", bus32.zero, exp == 0);
      tick();
    end
  endtask

  task automatic sweep8();
    logic [1:0] op; logic [7:0] a, b; logic [31:0] exp; int lat;
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom_range(3)); a = 8'($urandom); b = 8'($urandom);
      if (i % 50 == 0) begin a = 8'h00; b = 8'h00; end
      exp = ref_op(op, {24'h0, a}, {24'h0, b}, 8);
      bus8.op = op; bus8.in1 = a; bus8.in2 = b; bus8.in_valid = 1'b1;
      tick();
      bus8.in_valid = 1'b0; bus8.in1 = ~a; bus8.in2 = ~b; bus8.op = ~op;
      lat = 0;
      while (!bus8.out_valid && lat < 32) begin tick(); lat++; end
      chk("w8_latency", lat, 8);
      chk("w8_out1", bus8.out1, exp);
      chk("w8_zero", bus8.zero, exp == 0);
      tick();
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;   bus.op = '0;   bus.in1 = '0;   bus.in2 = '0;   bus.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.op = '0; bus32.in1 = '0; bus32.in2 = '0; bus32.out_ready = 1'b1;
    bus8.in_valid = 1'b0;  bus8.op = '0;  bus8.in1 = '0;  bus8.in2 = '0;  bus8.out_ready = 1'b1;

    rst = 1'b1;
    tick(); tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out1", bus.out1, 0);
    chk("rst_zero", bus.zero, 0);
    rst = 1'b0;
    tick();

    // AND vector, then back to IDLE with result retained
    req32(2'b00, 32'hF0F0_1234, 32'hFF00_FF0F, "and");
    chk("and_out1", bus.out1, 32'hF000_1204);
    chk("and_zero", bus.zero, 0);
    tick();
    chk("and_idle", bus.in_ready, 1);
    chk("and_out_valid_low", bus.out_valid, 0);
    chk("and_retain", bus.out1, 32'hF000_1204);

    req32(2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "xor");
    chk("xor_out1", bus.out1, 32'h0000_0000);
    chk("xor_zero", bus.zero, 1);
    tick();
    req32(2'b11, 32'h0, 32'h0, "nor");
    chk("nor_out1", bus.out1, 32'hFFFF_FFFF);
    chk("nor_zero", bus.zero, 0);
    tick();

    // Operand change during BUSY is ignored
    req32(2'b01, 32'h0000_00FF, 32'h0F00_0000, "or_mid");
    chk("or_mid_out1", bus.out1, 32'h0F00_00FF);
    tick();

    // Back-pressure: hold DONE, wiggle inputs
    bus.out_ready = 1'b0;
    req32(2'b01, 32'h1234_0000, 32'h0000_5678, "bp");
    for (int i = 0; i < 10; i++) begin
      bus.in1 = $urandom; bus.in2 = $urandom; bus.in_valid = i[0];
      tick();
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out1", bus.out1, 32'h1234_5678);
      chk("bp_zero", bus.zero, 0);
    end
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("bp_release_idle", bus.in_ready, 1);
    chk("bp_release_valid", bus.out_valid, 0);
    tick();
    chk("no_reaccept", bus.in_ready, 1);

    // Reset after two chunks aborts the operation
    bus.op = 2'b01; bus.in1 = 32'hAAAA_AAAA; bus.in2 = 32'h5555_5555; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out1", bus.out1, 0);
    chk("abort_zero", bus.zero, 0);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_valid", bus.out_valid, 0);
      tick();
    end
    req32(2'b10, 32'h0F0F_0F0F, 32'hFFFF_FFFF, "post_abort");
    chk("post_abort_out1", bus.out1, 32'hF0F0_F0F0);
    tick();

    // Reset while DONE discards the result
    bus.out_ready = 1'b0;
    req32(2'b00, 32'hFFFF_FFFF, 32'h0000_FFFF, "done_rst");
    chk("done_rst_pre", bus.out1, 32'h0000_FFFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    chk("done_rst_out1", bus.out1, 0);
    chk("done_rst_valid", bus.out_valid, 0);
    chk("done_rst_in_ready", bus.in_ready, 1);

    sweep32();
    sweep8();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/logic_unit_seq.md
LOGIC_UNIT_SEQ -- requirements
Module: logic_unit_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CHUNK, default 8, bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK, else elaboration SHALL fail; NCH = WIDTH/CHUNK.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  request present.
REQ-006 Port in_ready  output  1  block can accept a request.
REQ-007 Port op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-008 Port in1, in2  input  WIDTH  operands.
REQ-009 Port out_valid  output  1  result present on out1/zero.
REQ-010 Port out_ready  input  1  consumer accepts result.
REQ-011 Port out1  output  WIDTH  registered result.
REQ-012 Port zero  output  1  registered flag, 1 when out1 == 0.

Function
REQ-013 FSM states IDLE, BUSY, DONE; all outputs driven from registers or state decode only (no combinational path from inputs to outputs).
REQ-014 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE.
REQ-015 Accept: in IDLE with in_valid=1 at an edge -> latch op, in1, in2; clear chunk counter cnt to 0; go to BUSY.
REQ-016 IDLE with in_valid=0 -> remain IDLE, no register change.
REQ-017 BUSY: each edge computes op on latched bits [cnt*CHUNK +: CHUNK], writes them to the internal accumulator at the same position, increments cnt; LSB chunk first.
REQ-018 BUSY edge where cnt == NCH-1 -> copy completed accumulator to out1, load zero = (result == 0), go to DONE.
REQ-019 Latency: out_valid SHALL first be high in the NCH-th cycle after the accept edge (32/8 -> 4 cycles; CHUNK == WIDTH -> 1 cycle).
REQ-020 in1, in2, op, in_valid changes during BUSY or DONE SHALL be ignored.
REQ-021 DONE: out1, zero held stable; out_ready=1 at an edge -> IDLE; out_ready=0 -> remain DONE indefinitely.
REQ-022 No same-cycle re-accept: in DONE, in_valid=1 with out_ready=1 SHALL NOT accept; request accepted at earliest on the following edge from IDLE.
REQ-023 out1 and zero SHALL retain the last completed result after leaving DONE, changing only at the next REQ-018 load.
REQ-024 NOR result bits SHALL be ~(a|b) masked to WIDTH; no bits beyond WIDTH exist anywhere in the datapath.
REQ-025 cnt width SHALL be ceil(log2(NCH)) with minimum 1 bit; cnt SHALL never exceed NCH-1.

Reset
REQ-026 rst=1 at an edge -> state IDLE, cnt=0, accumulator=0, out1=0, zero=0, latched operands/op=0; in_ready=1, out_valid=0 in the following cycle.
REQ-027 rst overrides all other inputs in any state; reset during BUSY aborts the operation, no out_valid SHALL appear for it.
REQ-028 rst during DONE discards the pending result; out1 SHALL read 0 afterwards.

Verification
REQ-029 WIDTH=32, CHUNK=8; op=00, in1=0xF0F0_1234, in2=0xFF00_FF0F, out_ready=1 -> out_valid high 4 cycles after accept, out1=0xF000_1204, zero=0, then IDLE.
REQ-030 op=10, in1=in2=0xDEAD_BEEF -> out1=0x0000_0000, zero=1; op=11, in1=0, in2=0 -> out1=0xFFFF_FFFF, zero=0.
REQ-031 Back-pressure: out_ready=0 for 10 cycles in DONE -> out_valid, out1, zero stable for all 10; toggle in1/in2/in_valid meanwhile -> no effect; out_ready=1 -> IDLE next cycle.
REQ-032 Operand change mid-BUSY: op=01, in1=0x0000_00FF, in2=0x0F00_0000 accepted, then in1 driven 0xFFFF_FFFF during BUSY -> out1=0x0F00_00FF.
REQ-033 Reset mid-BUSY after 2 chunks -> in_ready=1 next cycle, out_valid never asserts, out1=0; subsequent request completes correctly.
REQ-034 Parameter sweep CHUNK=32 (1-cycle) and WIDTH=8/CHUNK=1 (8-cycle): random operands/ops over 1000 back-to-back requests match reference model, latency exactly NCH.
